// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared state encoding and defaults for the pipeline controller
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam int TIMEOUT_CYC_DEF = 64;
  localparam int DRAIN_CYCLES    = 4;

endpackage

// File: rtl/pipeline_ctrl_sat_cnt.sv
// rtl/pipeline_ctrl_sat_cnt.sv - saturating up-counter with synchronous clear
module sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard/stall/flush control for a 5-stage pipeline with debug halt
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             mem_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             halt_ack,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err_timeout
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  state_e            state_q, state_d;
  logic [1:0]        drain_cnt_q, drain_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic              mem_stall, load_use;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign load_use  = idex_memread & (idex_rd != 5'd0) &
                     ((idex_rd == id_rs1) | (idex_rd == id_rs2));

  always_comb begin
    pc_en        = 1'b1;
    pc_sel       = 1'b0;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_en    = 1'b1;
    mem_wb_flush = 1'b0;
    halt_ack     = 1'b0;
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;

    if (state_q == ST_HALTED) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      halt_ack  = 1'b1;
    end else if (mem_stall) begin
      // Freeze everything upstream of MEM and push a bubble into WB.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (mem_redirect) begin
      pc_sel       = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
      // While draining, stop fetching and feed bubbles behind the last instruction.
      if (state_q == ST_DRAIN) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
    end

    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 2'd0;
        end
      end
      ST_DRAIN: begin
        if (!halt_req) begin
          state_d     = ST_RUN;
          drain_cnt_d = 2'd0;
        end else if (!mem_stall && !load_use) begin
          if (drain_cnt_q == 2'(DRAIN_CYCLES - 1)) begin
            state_d     = ST_HALTED;
            drain_cnt_d = 2'd0;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      ST_HALTED: begin
        if (!halt_req) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d     = ST_RUN;
        drain_cnt_d = 2'd0;
      end
    endcase
  end

  always_comb begin
    wait_cnt_d = '0;
    err_d      = err_q;
    if (mem_stall && state_q != ST_HALTED) begin
      wait_cnt_d = (wait_cnt_q == WAIT_W'(TIMEOUT_CYC)) ? wait_cnt_q : wait_cnt_q + 1'b1;
      if (wait_cnt_d == WAIT_W'(TIMEOUT_CYC)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 2'd0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
    end
  end

  assign err_timeout = err_q;

  sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (~pc_en & (state_q != ST_HALTED)),
    .clr    (1'b0),
    .cnt    (stall_cnt)
  );

  // pc_sel is only raised when a redirect actually wins priority.
  sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (pc_sel),
    .clr    (1'b0),
    .cnt    (flush_cnt)
  );

endmodule
